// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes, operand/bypass selects and
// the iterative multiply/divide state encoding.
package exec_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SRL    = 5'd3,
        ALU_SRA    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_SLTU   = 5'd6,
        ALU_XOR    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_IMM   = 2'd0,
        SRC_RD2   = 2'd1,
        SRC_PC4   = 2'd2,
        SRC_PCIMM = 2'd3
    } alu_src_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_M    = 2'd1,
        FWD_W    = 2'd2
    } fwd_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

endpackage

// File: rtl/execute_unit_muldiv.sv
// Iterative RV32M unit: one shift-add (multiply) or restoring-subtract (divide)
// step per cycle on operand magnitudes, sign-corrected when the result is read.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    md_state_t         state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [4:0]        op_r;
    logic              is_div_r, a_neg_r, b_neg_r, b_zero_r;
    logic [XLEN-1:0]   hi_r, lo_r, mag_r;

    logic              a_signed, b_signed, a_neg, b_neg, is_div;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    always_ff @(posedge clk) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_BUSY;
            MD_BUSY: begin
                if (flush)             state_nxt = MD_IDLE;
                else if (cnt == LAST)  state_nxt = MD_DONE;
            end
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    assign busy = (state == MD_BUSY);
    assign done = (state == MD_DONE);

    always_ff @(posedge clk) begin
        if (reset || !busy) cnt <= '0;
        else                cnt <= cnt + 1'b1;
    end

    always_comb begin
        a_signed = (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_DIV) || (op == ALU_REM);
        b_signed = (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        a_abs    = a_neg ? -a : a;
        b_abs    = b_neg ? -b : b;
        is_div   = (op >= ALU_DIV);
    end

    // Multiply: hi:lo is the running product, lo shifts the multiplier out.
    // Divide: lo shifts the dividend out and collects quotient bits, hi is the remainder.
    assign mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mag_r} : '0);
    assign div_shift = {hi_r, lo_r[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mag_r};

    always_ff @(posedge clk) begin
        if (start && state == MD_IDLE) begin
            op_r     <= op;
            is_div_r <= is_div;
            a_neg_r  <= a_neg;
            b_neg_r  <= b_neg;
            b_zero_r <= (b == '0);
            hi_r     <= '0;
            lo_r     <= is_div ? a_abs : b_abs;
            mag_r    <= is_div ? b_abs : a_abs;
        end else if (busy) begin
            if (is_div_r) begin
                if (!div_diff[XLEN]) begin
                    hi_r <= div_diff[XLEN-1:0];
                    lo_r <= {lo_r[XLEN-2:0], 1'b1};
                end else begin
                    hi_r <= div_shift[XLEN-1:0];
                    lo_r <= {lo_r[XLEN-2:0], 1'b0};
                end
            end else begin
                hi_r <= mul_sum[XLEN:1];
                lo_r <= {mul_sum[0], lo_r[XLEN-1:1]};
            end
        end
    end

    // Remainder takes the dividend's sign; a zero divisor forces an all-ones quotient.
    always_comb begin
        prod   = {hi_r, lo_r};
        prod_s = (a_neg_r ^ b_neg_r) ? -prod : prod;
        quo_s  = b_zero_r ? '1 : ((a_neg_r ^ b_neg_r) ? -lo_r : lo_r);
        rem_s  = a_neg_r ? -hi_r : hi_r;
        result = '0;
        case (op_r)
            ALU_MUL:                         result = prod_s[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod_s[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:               result = quo_s;
            ALU_REM, ALU_REMU:               result = rem_s;
            default:                         result = '0;
        endcase
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: bypass muxes, RV32I ALU and the E/M pipeline register.
// Define EXECUTE_MULDIV_EN to include the iterative RV32M unit and its stall.
module execute_unit
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            validE,
    input  logic            regWriteE,
    input  logic            memWriteE,
    input  logic            mem2regE,
    input  logic            branchE,
    input  logic            finishE,
    input  logic [XLEN-1:0] rdata1E,
    input  logic [XLEN-1:0] rdata2E,
    input  logic [XLEN-1:0] immE,
    input  logic [XLEN-1:0] pcE,
    input  logic [REGW-1:0] writeRegE,
    input  logic [4:0]      ALUControlE,
    input  logic [1:0]      ALUSrcE,
    input  logic [1:0]      forward1,
    input  logic [1:0]      forward2,
    input  logic [XLEN-1:0] resultW,
    input  logic            validW,
    input  logic            flushE,
    output logic            stallE,
    output logic [XLEN-1:0] writeDataM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] pcM,
    output logic [REGW-1:0] writeRegM,
    output logic            regWriteM,
    output logic            memWriteM,
    output logic            mem2regM,
    output logic            zeroM,
    output logic            branchM,
    output logic            finishM,
    output logic            validM
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] op1_e, op2_e, src1_e, src2_e, alu_e, result_e;
    logic [SHW-1:0]  shamt_e;
    logic            hold_e, issue_e;

    always_comb begin
        op1_e = rdata1E;
        if (forward1 == FWD_M && validM)      op1_e = ALUResultM;
        else if (forward1 == FWD_W && validW) op1_e = resultW;
        op2_e = rdata2E;
        if (forward2 == FWD_M && validM)      op2_e = ALUResultM;
        else if (forward2 == FWD_W && validW) op2_e = resultW;
    end

    always_comb begin
        src1_e = op1_e;
        src2_e = op2_e;
        case (ALUSrcE)
            SRC_IMM:   src2_e = immE;
            SRC_PC4: begin
                src1_e = pcE;
                src2_e = XLEN'(4);
            end
            SRC_PCIMM: begin
                src1_e = pcE;
                src2_e = immE;
            end
            default: ;
        endcase
    end

    assign shamt_e = src2_e[SHW-1:0];

    always_comb begin
        alu_e = '0;
        case (ALUControlE)
            ALU_ADD:  alu_e = src1_e + src2_e;
            ALU_SUB:  alu_e = src1_e - src2_e;
            ALU_SLL:  alu_e = src1_e << shamt_e;
            ALU_SRL:  alu_e = src1_e >> shamt_e;
            ALU_SRA:  alu_e = $signed(src1_e) >>> shamt_e;
            ALU_SLT:  alu_e = {{(XLEN-1){1'b0}}, $signed(src1_e) < $signed(src2_e)};
            ALU_SLTU: alu_e = {{(XLEN-1){1'b0}}, src1_e < src2_e};
            ALU_XOR:  alu_e = src1_e ^ src2_e;
            ALU_OR:   alu_e = src1_e | src2_e;
            ALU_AND:  alu_e = src1_e & src2_e;
            default:  alu_e = '0;
        endcase
    end

`ifdef EXECUTE_MULDIV_EN
    logic            md_op_e, md_start_e, md_busy, md_done;
    logic [XLEN-1:0] md_result;

    // Operands are taken straight from the bypass muxes, ignoring ALUSrc.
    assign md_op_e    = validE & is_muldiv(ALUControlE);
    assign md_start_e = md_op_e & ~flushE & ~reset & ~md_busy & ~md_done;

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_e),
        .flush  (flushE),
        .op     (ALUControlE),
        .a      (op1_e),
        .b      (op2_e),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign stallE   = md_start_e | (md_busy & ~flushE & ~reset);
    assign hold_e   = md_op_e & ~md_done;
    assign result_e = (md_op_e & md_done) ? md_result : alu_e;
`else
    assign stallE   = 1'b0;
    assign hold_e   = 1'b0;
    assign result_e = alu_e;
`endif

    assign issue_e = validE & ~flushE & ~hold_e;

    // E/M boundary: bubbles clear the whole M word so nothing stale is forwarded.
    always_ff @(posedge clk) begin
        if (reset || !issue_e) begin
            writeDataM <= '0;
            ALUResultM <= '0;
            pcM        <= '0;
            writeRegM  <= '0;
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            mem2regM   <= 1'b0;
            zeroM      <= 1'b0;
            branchM    <= 1'b0;
            finishM    <= 1'b0;
            validM     <= 1'b0;
        end else begin
            writeDataM <= op2_e;
            ALUResultM <= result_e;
            pcM        <= pcE;
            writeRegM  <= writeRegE;
            regWriteM  <= regWriteE;
            memWriteM  <= memWriteE;
            mem2regM   <= mem2regE;
            zeroM      <= (result_e == '0);
            branchM    <= branchE;
            finishM    <= finishE;
            validM     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit; muldiv expectations follow EXECUTE_MULDIV_EN.
module tb_execute_unit;
    import exec_pkg::*;

    logic        clk, reset;
    logic        validE, regWriteE, memWriteE, mem2regE, branchE, finishE;
    logic [31:0] rdata1E, rdata2E, immE, pcE, resultW;
    logic [4:0]  writeRegE, ALUControlE;
    logic [1:0]  ALUSrcE, forward1, forward2;
    logic        validW, flushE, stallE;
    logic [31:0] writeDataM, ALUResultM, pcM;
    logic [4:0]  writeRegM;
    logic        regWriteM, memWriteM, mem2regM, zeroM, branchM, finishM, validM;

    int n_assert = 0;
    int n_fail   = 0;

    execute_unit #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .reset(reset), .validE(validE), .regWriteE(regWriteE),
        .memWriteE(memWriteE), .mem2regE(mem2regE), .branchE(branchE), .finishE(finishE),
        .rdata1E(rdata1E), .rdata2E(rdata2E), .immE(immE), .pcE(pcE),
        .writeRegE(writeRegE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .forward1(forward1), .forward2(forward2), .resultW(resultW), .validW(validW),
        .flushE(flushE), .stallE(stallE), .writeDataM(writeDataM), .ALUResultM(ALUResultM),
        .pcM(pcM), .writeRegM(writeRegM), .regWriteM(regWriteM), .memWriteM(memWriteM),
        .mem2regM(mem2regM), .zeroM(zeroM), .branchM(branchM), .finishM(finishM),
        .validM(validM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        validE = 1'b1; regWriteE = 1'b1; memWriteE = 1'b0; mem2regE = 1'b0;
        branchE = 1'b0; finishE = 1'b0; flushE = 1'b0;
        ALUControlE = op; ALUSrcE = SRC_RD2; rdata1E = a; rdata2E = b;
        immE = 32'h0; pcE = 32'h0; writeRegE = 5'd1;
        forward1 = FWD_NONE; forward2 = FWD_NONE; validW = 1'b0; resultW = 32'h0;
    endtask

`ifdef EXECUTE_MULDIV_EN
    task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int cyc, output logic vld);
        alu(op, a, b);
        #1;
        cyc = 0;
        while (stallE && cyc < 40) begin
            cyc++;
            tick();
        end
        tick();
        res = ALUResultM;
        vld = validM;
        validE = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int seen;
        logic [31:0] r;
        int cyc;
        logic v;
        seen = 0; r = '0; cyc = 0; v = 1'b0;

        reset = 1'b1;
        alu(ALU_ADD, 32'd0, 32'd0);
        validE = 1'b0;
        tick(); tick();
        check("rst_validM", {31'b0, validM}, 32'd0);
        check("rst_result", ALUResultM, 32'd0);
        check("rst_stallE", {31'b0, stallE}, 32'd0);
        check("rst_regWriteM", {31'b0, regWriteM}, 32'd0);
        reset = 1'b0;

        alu(ALU_ADD, 32'd5, 32'd7); writeRegE = 5'd3;
        tick();
        check("add_result", ALUResultM, 32'd12);
        check("add_validM", {31'b0, validM}, 32'd1);
        check("add_writeRegM", {27'b0, writeRegM}, 32'd3);
        check("add_zeroM", {31'b0, zeroM}, 32'd0);

        alu(ALU_SUB, 32'd20, 32'd999); forward2 = FWD_M;
        tick();
        check("sub_fwdM_result", ALUResultM, 32'd8);
        check("sub_fwdM_wdata", writeDataM, 32'd12);

        alu(ALU_SRA, 32'h8000_0000, 32'd4);
        tick();
        check("sra_result", ALUResultM, 32'hF800_0000);
        check("sra_validM", {31'b0, validM}, 32'd1);

        alu(ALU_SRL, 32'h8000_0000, 32'd4);  tick(); check("srl", ALUResultM, 32'h0800_0000);
        alu(ALU_SLL, 32'd1, 32'd33);         tick(); check("sll_shamt_wrap", ALUResultM, 32'd2);
        alu(ALU_SLT, 32'hFFFF_FFFF, 32'd1);  tick(); check("slt", ALUResultM, 32'd1);
        alu(ALU_SLTU, 32'hFFFF_FFFF, 32'd1); tick(); check("sltu", ALUResultM, 32'd0);
        check("sltu_zeroM", {31'b0, zeroM}, 32'd1);
        alu(ALU_XOR, 32'hF0F0, 32'hFF00);    tick(); check("xor", ALUResultM, 32'h0FF0);
        alu(ALU_OR, 32'hF0F0, 32'hFF00);     tick(); check("or", ALUResultM, 32'hFFF0);
        alu(ALU_AND, 32'hF0F0, 32'hFF00);    tick(); check("and", ALUResultM, 32'hF000);

        alu(ALU_ADD, 32'd5, 32'd0); ALUSrcE = SRC_IMM; immE = 32'h23;
        forward1 = FWD_W; validW = 1'b1; resultW = 32'h100;
        tick();
        check("imm_fwdW", ALUResultM, 32'h123);
        alu(ALU_ADD, 32'd5, 32'd0); ALUSrcE = SRC_IMM; immE = 32'h23;
        forward1 = FWD_W; validW = 1'b0; resultW = 32'h100;
        tick();
        check("imm_fwdW_invalid", ALUResultM, 32'h28);

        alu(ALU_ADD, 32'd0, 32'd0); ALUSrcE = SRC_PC4; pcE = 32'h1000;
        tick();
        check("pc4", ALUResultM, 32'h1004);
        check("pc4_pcM", pcM, 32'h1000);
        alu(ALU_ADD, 32'd0, 32'd0); ALUSrcE = SRC_PCIMM; pcE = 32'h1000; immE = 32'h20;
        tick();
        check("pcimm", ALUResultM, 32'h1020);

        alu(5'd31, 32'd9, 32'd9);
        tick();
        check("undef_result", ALUResultM, 32'd0);
        check("undef_zeroM", {31'b0, zeroM}, 32'd1);

        alu(ALU_ADD, 32'd1, 32'd1); validE = 1'b0; memWriteE = 1'b1;
        tick();
        check("bubble_validM", {31'b0, validM}, 32'd0);
        check("bubble_regWriteM", {31'b0, regWriteM}, 32'd0);
        check("bubble_memWriteM", {31'b0, memWriteM}, 32'd0);

        alu(ALU_ADD, 32'h10, 32'd1); forward1 = FWD_M;
        tick();
        check("fwdM_invalid", ALUResultM, 32'h11);

        alu(ALU_ADD, 32'd4, 32'd4); memWriteE = 1'b1; mem2regE = 1'b1;
        branchE = 1'b1; finishE = 1'b1;
        tick();
        check("ctl_flags", {28'b0, memWriteM, mem2regM, branchM, finishM}, 32'hF);

        alu(ALU_ADD, 32'd1, 32'd1); flushE = 1'b1;
        tick();
        check("flush_validM", {31'b0, validM}, 32'd0);
        flushE = 1'b0;

        alu(ALU_ADD, 32'd3, 32'd4); tick();
        reset = 1'b1; writeRegE = 5'd9;
        tick();
        check("rst_mid_result", ALUResultM, 32'd0);
        check("rst_mid_wdata", writeDataM, 32'd0);
        check("rst_mid_ctl", {26'b0, writeRegM, validM}, 32'd0);
        reset = 1'b0;

`ifdef EXECUTE_MULDIV_EN
        run_md(ALU_MULH, 32'hFFFF_FFFF, 32'd3, r, cyc, v);
        check("mulh_stall_cycles", cyc, 32'd33);
        check("mulh_result", r, 32'hFFFF_FFFF);
        check("mulh_validM", {31'b0, v}, 32'd1);
        tick();
        check("mulh_once", {31'b0, validM}, 32'd0);

        run_md(ALU_MUL, 32'hFFFF_FFFF, 32'd3, r, cyc, v);   check("mul_lo", r, 32'hFFFF_FFFD);
        run_md(ALU_DIV, 32'd7, 32'd0, r, cyc, v);           check("div_by0", r, 32'hFFFF_FFFF);
        run_md(ALU_REM, 32'd7, 32'd0, r, cyc, v);           check("rem_by0", r, 32'd7);
        run_md(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, cyc, v); check("div_ovf", r, 32'h8000_0000);
        run_md(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, cyc, v); check("rem_ovf", r, 32'd0);
        run_md(ALU_DIV, 32'hFFFF_FFF9, 32'd2, r, cyc, v);   check("div_neg", r, 32'hFFFF_FFFD);
        run_md(ALU_REM, 32'hFFFF_FFF9, 32'd2, r, cyc, v);   check("rem_neg", r, 32'hFFFF_FFFF);
        run_md(ALU_DIVU, 32'd100, 32'd7, r, cyc, v);        check("divu", r, 32'd14);

        alu(ALU_DIVU, 32'd100, 32'd7);
        tick();
        repeat (9) tick();
        flushE = 1'b1;
        #1;
        check("flush_busy_stallE", {31'b0, stallE}, 32'd0);
        tick();
        flushE = 1'b0; validE = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (validM) seen++;
            tick();
        end
        check("flush_no_result", seen, 32'd0);
        alu(ALU_ADD, 32'd1, 32'd2);
        tick();
        check("after_flush_add", ALUResultM, 32'd3);

        alu(ALU_MUL, 32'd5, 32'd6);
        repeat (5) tick();
        reset = 1'b1; validE = 1'b0;
        tick();
        check("rst_md_stallE", {31'b0, stallE}, 32'd0);
        check("rst_md_validM", {31'b0, validM}, 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (validM) seen++;
            tick();
        end
        check("rst_md_no_result", seen, 32'd0);
        alu(ALU_ADD, 32'd2, 32'd3);
        #1;
        check("rst_md_add_stallE", {31'b0, stallE}, 32'd0);
        tick();
        check("rst_md_add", ALUResultM, 32'd5);
        check("rst_md_add_validM", {31'b0, validM}, 32'd1);
`else
        alu(ALU_MUL, 32'd3, 32'd4);
        #1;
        check("nomd_stallE", {31'b0, stallE}, 32'd0);
        tick();
        check("nomd_mul_result", ALUResultM, 32'd0);
        check("nomd_mul_validM", {31'b0, validM}, 32'd1);
        alu(ALU_DIV, 32'd7, 32'd0);
        tick();
        check("nomd_div_zeroM", {31'b0, zeroM}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
- Parametrised next-generation execute stage for the pipelined core.
- Full RV32I integer ALU plus an iterative RV32M multiply/divide unit; bypass selection from M and W; stall/flush handshake to the hazard unit.
- Registers all results into the E/M pipeline register.
- Sits between decode and memory; multi-cycle ops stall upstream stages while M receives bubbles.

Parameters:
- XLEN, 32, datapath width; must be a power of two, at least 8.
- REGW, 5, register-index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- validE, regWriteE, memWriteE, mem2regE, branchE, finishE  in  1 each  decode control/valid.
- rdata1E, rdata2E, immE, pcE  in  XLEN each  operands, immediate, PC.
- writeRegE  in  REGW  destination register.
- ALUControlE  in  5  opcode (alu_op_t).
- ALUSrcE  in  2  operand select (alu_src_t).
- forward1, forward2  in  2 each  bypass select: NONE, M, W.
- resultW  in  XLEN  writeback value.
- validW  in  1  writeback valid.
- flushE  in  1  squash the E instruction and abort any muldiv.
- stallE  out  1  upstream must hold all E inputs.
- writeDataM, ALUResultM, pcM  out  XLEN each  M-stage data.
- writeRegM  out  REGW  M-stage destination register.
- regWriteM, memWriteM, mem2regM, zeroM, branchM, finishM, validM  out  1 each  M-stage control.

Behaviour:
- Reset: every M output is 0, stallE = 0, FSM in IDLE, iteration counter 0.
- Bypass (per operand, independent):
  - fwd = M and validM: use ALUResultM.
  - else fwd = W and validW: use resultW.
  - else: use the register-file value.
  - Operand 2 uses forward2.
  - writeDataM takes bypassed operand 2.
- ALUSrc:
  - IMM: (op1, imm).
  - RD2: (op1, op2).
  - PC4: (pc, 4).
  - PCIMM: (pc, imm).
  - Muldiv ops always use (op1, op2).
- Single-cycle ops (1-cycle latency to M): ADD, SUB, SLL, SRL, SRA, SLT, SLTU, XOR, OR, AND.
  - Shifts use the low log2(XLEN) bits of src2.
  - Undefined opcode yields result 0; no simulation messages.
- zeroE = (result == 0), registered as zeroM.
- Muldiv ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. FSM is IDLE -> BUSY -> DONE -> IDLE.
  - IDLE, validE, muldiv op, no flushE: stallE = 1 combinationally. On the edge, latch absolute values of the operands, sign flags and op, clear the counter, go to BUSY. M loads a bubble.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle. stallE = 1; M receives bubbles. When the counter reaches XLEN-1, go to DONE.
  - DONE: stallE = 0. Apply sign correction and select hi/lo or quotient/remainder. E-side controls, held stable by upstream, are captured with the result and validM = 1. Return to IDLE.
  - Latency: presentation cycle t gives the result in M at edge t+XLEN+2.
  - Operands are sampled at cycle t only; bypass values during BUSY are ignored.
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
- flushE: M loads a bubble next edge. In BUSY or DONE, abort to IDLE with no result issued. stallE drops in the same cycle.
- Reset mid-operation: IDLE with outputs cleared, as for reset.
- validE = 0: bubble propagates; validM = 0 and regWriteM/memWriteM forced 0.

Optional Feature:
- EXECUTE_MULDIV_EN defined: muldiv FSM and datapath present as above.
- Undefined: muldiv opcodes behave as undefined opcodes (result 0, single cycle); stallE tied 0; no FSM or iterative datapath synthesised.

Decomposition:
- Package exec_pkg holds:
  - alu_op_t (5-bit enum, all 18 ops).
  - alu_src_t {IMM, RD2, PC4, PCIMM}.
  - fwd_t {NONE, M, W}.
  - md_state_t {IDLE, BUSY, DONE}.
  - An is_muldiv() function.
- Sub-module muldiv_iter holds the FSM, counter and shift registers. Start/busy/done interface; inputs: op, a, b, flush; output: result.

Test Plan:
- ADD 5+7, then SRA 0x80000000 by 4 -> ALUResultM 12, then 0xF8000000; validM 1 one edge after each.
- Previous result 12 in M, forward2 = M, SUB rdata1 = 20 -> ALUResultM 8, writeDataM 12.
- MUL 0xFFFFFFFF x 3 (MULH) -> stallE high for 33 cycles, then ALUResultM 0xFFFFFFFF at t+34 with validM 1 once.
- DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000 / -1 -> 0x80000000; REM of same -> 0.
- DIVU issued, flushE pulsed in BUSY cycle 10 -> stallE low that cycle, no validM result, next ADD completes normally.
- reset asserted mid-MUL -> all M outputs 0 next edge, stallE 0, following instruction executes in 1 cycle.
